// File: rtl/wash_timer_scan.sv
// -----------------------------------------------------------------------------
// wash_timer_scan
//   Washing-machine style countdown timer (MM:SS in BCD) with a four-digit
//   multiplexed seven-segment scan driver.
//
// Parameters
//   TICK_DIV  clk cycles per countdown second (>= 2)
//   SCAN_DIV  clk cycles per display digit slot (>= 2)
//
// Ports
//   clk       sole clock, rising edge
//   rst       synchronous active-high reset
//   load      one-cycle request to load load_min/load_sec (IDLE/PAUSED only)
//   load_min  BCD minutes {tens,ones}
//   load_sec  BCD seconds {tens,ones}
//   start     one-cycle request to begin/resume the countdown
//   pause     one-cycle request to suspend the countdown
//   run       high while counting down
//   done      one-cycle pulse when the countdown reaches 00:00
//   time_min  current BCD minutes
//   time_sec  current BCD seconds
//   digit     BCD code for the 7-seg decoder, 4'hF = blank
//   an        active-low one-hot digit enable
// -----------------------------------------------------------------------------
module wash_timer_scan #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned SCAN_DIV = 50_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  input  logic       start,
  input  logic       pause,
  output logic       run,
  output logic       done,
  output logic [7:0] time_min,
  output logic [7:0] time_sec,
  output logic [3:0] digit,
  output logic [3:0] an
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [7:0]     min_q, min_d;
  logic [7:0]     sec_q, sec_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic           done_q, done_d;
  logic [SW-1:0]  scan_q, scan_d;
  logic [1:0]     slot_q, slot_d;
  logic [3:0]     digit_q, digit_d;
  logic [3:0]     an_q, an_d;

  logic           load_ok;
  logic [7:0]     cur_min;
  logic [7:0]     cur_sec;
  logic [15:0]    dec_time;

  // Minutes 00-99, seconds 00-59, every nibble a legal BCD digit.
  function automatic logic bcd_valid(input logic [7:0] m, input logic [7:0] s);
    return (m[7:4] <= 4'd9) && (m[3:0] <= 4'd9) &&
           (s[7:4] <= 4'd5) && (s[3:0] <= 4'd9);
  endfunction

  // One-second BCD decrement of {min,sec}; never called with 00:00.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [3:0] mt, mo, st, so;
    mt = t[15:12];
    mo = t[11:8];
    st = t[7:4];
    so = t[3:0];
    if (so != 4'd0) begin
      so = so - 4'd1;
    end else begin
      so = 4'd9;
      if (st != 4'd0) begin
        st = st - 4'd1;
      end else begin
        st = 4'd5;
        if (mo != 4'd0) begin
          mo = mo - 4'd1;
        end else begin
          mo = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  // Digit shown in a slot; only the minute-tens position is blanked when zero.
  function automatic logic [3:0] digit_sel(input logic [1:0] slot,
                                           input logic [7:0] m,
                                           input logic [7:0] s);
    logic [3:0] d;
    case (slot)
      2'd0:    d = s[3:0];
      2'd1:    d = s[7:4];
      2'd2:    d = m[3:0];
      2'd3:    d = (m[7:4] == 4'd0) ? 4'hF : m[7:4];
      default: d = 4'hF;
    endcase
    return d;
  endfunction

  // Countdown control: load, start/pause arbitration, prescaler and decrement.
  always_comb begin
    state_d  = state_q;
    min_d    = min_q;
    sec_d    = sec_q;
    presc_d  = presc_q;
    done_d   = 1'b0;
    load_ok  = load && (state_q != ST_RUN) && bcd_valid(load_min, load_sec);
    // start acting on the same cycle as a load sees the freshly loaded time
    cur_min  = load_ok ? load_min : min_q;
    cur_sec  = load_ok ? load_sec : sec_q;
    dec_time = bcd_dec({min_q, sec_q});

    case (state_q)
      ST_IDLE: begin
        presc_d = '0;
        if (load_ok) begin
          min_d = load_min;
          sec_d = load_sec;
        end else begin
          min_d = min_q;
        end
        if (start && !pause && ({cur_min, cur_sec} != 16'h0000)) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PAUSED: begin
        if (load_ok) begin
          min_d   = load_min;
          sec_d   = load_sec;
          presc_d = '0;
        end else begin
          presc_d = presc_q;
        end
        if (start && !pause && ({cur_min, cur_sec} != 16'h0000)) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_PAUSED;
        end
      end
      ST_RUN: begin
        if (presc_q == PRESC_MAX) begin
          presc_d = '0;
          min_d   = dec_time[15:8];
          sec_d   = dec_time[7:0];
          // reaching zero ends the run even if pause arrives in the same cycle
          if (dec_time == 16'h0000) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (pause) begin
            state_d = ST_PAUSED;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          presc_d = presc_q + PW'(1);
          if (pause) begin
            state_d = ST_PAUSED;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        presc_d = '0;
      end
    endcase
  end

  // Display scan: free-running slot timer; digit and an are computed from the
  // same next slot so they always change together.
  always_comb begin
    scan_d = scan_q;
    slot_d = slot_q;
    if (scan_q == SCAN_MAX) begin
      scan_d = '0;
      slot_d = slot_q + 2'd1;
    end else begin
      scan_d = scan_q + SW'(1);
    end
    an_d    = ~(4'b0001 << slot_d);
    digit_d = digit_sel(slot_d, min_q, sec_q);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      min_q   <= 8'h00;
      sec_q   <= 8'h00;
      presc_q <= '0;
      done_q  <= 1'b0;
      scan_q  <= '0;
      slot_q  <= 2'd0;
      digit_q <= 4'h0;
      an_q    <= 4'b1110;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      presc_q <= presc_d;
      done_q  <= done_d;
      scan_q  <= scan_d;
      slot_q  <= slot_d;
      digit_q <= digit_d;
      an_q    <= an_d;
    end
  end

  assign run      = (state_q == ST_RUN);
  assign done     = done_q;
  assign time_min = min_q;
  assign time_sec = sec_q;
  assign digit    = digit_q;
  assign an       = an_q;

endmodule

// File: tb/tb_wash_timer_scan.sv
// -----------------------------------------------------------------------------
// tb_wash_timer_scan
//   Table-driven bench for wash_timer_scan with TICK_DIV=4, SCAN_DIV=2.
//   Each table row is one clock cycle of inputs plus the expected run/done/
//   time after that edge; the expected display (an/digit) comes from a small
//   slot model fed by the table's own expected times. Expected records go to a
//   scoreboard queue when a row is driven and are popped after the edge.
// -----------------------------------------------------------------------------
module tb_wash_timer_scan;

  logic       clk;
  logic       rst;
  logic       load;
  logic [7:0] load_min;
  logic [7:0] load_sec;
  logic       start;
  logic       pause;
  logic       run;
  logic       done;
  logic [7:0] time_min;
  logic [7:0] time_sec;
  logic [3:0] digit;
  logic [3:0] an;

  int checks   = 0;
  int failures = 0;

  wash_timer_scan #(.TICK_DIV(4), .SCAN_DIV(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_min (load_min),
    .load_sec (load_sec),
    .start    (start),
    .pause    (pause),
    .run      (run),
    .done     (done),
    .time_min (time_min),
    .time_sec (time_sec),
    .digit    (digit),
    .an       (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       ld;
    logic [7:0] lm;
    logic [7:0] ls;
    logic       st;
    logic       pa;
    logic       e_run;
    logic       e_done;
    logic [7:0] e_min;
    logic [7:0] e_sec;
  } vec_t;

  typedef struct {
    int         idx;
    logic       run;
    logic       done;
    logic [7:0] mn;
    logic [7:0] sc;
    logic [3:0] an;
    logic [3:0] dg;
  } exp_t;

  vec_t vec_q[$];
  exp_t sb_q[$];

  task automatic row(input logic r, input logic ld, input logic [7:0] lm,
                     input logic [7:0] ls, input logic st, input logic pa,
                     input logic er, input logic ed, input logic [7:0] em,
                     input logic [7:0] es);
    vec_t v;
    v.r = r; v.ld = ld; v.lm = lm; v.ls = ls; v.st = st; v.pa = pa;
    v.e_run = er; v.e_done = ed; v.e_min = em; v.e_sec = es;
    vec_q.push_back(v);
  endtask

  task automatic idle(input int n, input logic er, input logic [7:0] em,
                      input logic [7:0] es);
    for (int k = 0; k < n; k++) row(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, er, 1'b0, em, es);
  endtask

  // Expected digit for a slot given the time displayed.
  function automatic logic [3:0] exp_digit(input int slot, input logic [7:0] m,
                                           input logic [7:0] s);
    if (slot == 0) return s[3:0];
    if (slot == 1) return s[7:4];
    if (slot == 2) return m[3:0];
    if (m[7:4] == 4'd0) return 4'hF;
    return m[7:4];
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_an(input logic [3:0] target, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 16 && !ok; k++) begin
      cyc();
      if (an === target) ok = 1'b1;
    end
  endtask

  initial begin
    vec_t v;
    exp_t e;
    exp_t g;
    int   m_scan;
    int   m_slot;
    logic [7:0] pm;
    logic [7:0] ps;
    int   n;
    bit   got;
    bit   ok;

    rst = 1'b1; load = 1'b0; load_min = 8'h00; load_sec = 8'h00;
    start = 1'b0; pause = 1'b0;
    m_scan = 0; m_slot = 0; pm = 8'h00; ps = 8'h00;

    // ---------------- stimulus / expectation table ----------------
    row(1,0,8'h00,8'h00,0,0, 0,0,8'h00,8'h00);          // reset
    idle(1, 0, 8'h00, 8'h00);
    row(0,0,8'h00,8'h00,1,0, 0,0,8'h00,8'h00);          // start at 00:00 ignored
    row(0,1,8'h00,8'h7A,0,0, 0,0,8'h00,8'h00);          // bad BCD rejected
    row(0,1,8'h00,8'h60,0,0, 0,0,8'h00,8'h00);          // 60 s rejected
    row(0,1,8'h01,8'h00,0,0, 0,0,8'h01,8'h00);          // load 01:00
    row(0,0,8'h00,8'h00,1,0, 1,0,8'h01,8'h00);          // enter RUN
    row(0,1,8'h05,8'h00,0,0, 1,0,8'h01,8'h00);          // load in RUN ignored
    idle(2, 1, 8'h01, 8'h00);
    idle(1, 1, 8'h00, 8'h59);                           // 4 RUN cycles
    idle(3, 1, 8'h00, 8'h59);
    idle(1, 1, 8'h00, 8'h58);
    idle(3, 1, 8'h00, 8'h58);
    idle(1, 1, 8'h00, 8'h57);                           // 8 more
    row(0,0,8'h00,8'h00,1,1, 0,0,8'h00,8'h57);          // start+pause in RUN
    row(0,0,8'h00,8'h00,1,1, 0,0,8'h00,8'h57);          // start+pause in PAUSED
    idle(2, 0, 8'h00, 8'h57);
    row(0,0,8'h00,8'h00,1,0, 1,0,8'h00,8'h57);          // resume, prescaler at 1
    idle(2, 1, 8'h00, 8'h57);
    idle(1, 1, 8'h00, 8'h56);
    row(1,0,8'h00,8'h00,0,0, 0,0,8'h00,8'h00);
    row(0,1,8'h00,8'h02,0,0, 0,0,8'h00,8'h02);          // 00:02 to done
    row(0,0,8'h00,8'h00,1,0, 1,0,8'h00,8'h02);
    idle(3, 1, 8'h00, 8'h02);
    idle(1, 1, 8'h00, 8'h01);
    idle(3, 1, 8'h00, 8'h01);
    row(0,0,8'h00,8'h00,0,0, 0,1,8'h00,8'h00);          // done, 8 after entry
    idle(2, 0, 8'h00, 8'h00);
    row(0,0,8'h00,8'h00,1,0, 0,0,8'h00,8'h00);          // start at 00:00 ignored
    row(0,1,8'h00,8'h05,0,0, 0,0,8'h00,8'h05);          // pause/resume case
    row(0,0,8'h00,8'h00,1,0, 1,0,8'h00,8'h05);
    idle(1, 1, 8'h00, 8'h05);
    row(0,0,8'h00,8'h00,0,1, 0,0,8'h00,8'h05);
    idle(10, 0, 8'h00, 8'h05);
    row(0,0,8'h00,8'h00,1,0, 1,0,8'h00,8'h05);
    idle(1, 1, 8'h00, 8'h05);
    idle(1, 1, 8'h00, 8'h04);                           // 2 after re-entry
    row(0,0,8'h00,8'h00,0,1, 0,0,8'h00,8'h04);
    row(0,1,8'h00,8'h09,0,0, 0,0,8'h00,8'h09);          // load in PAUSED clears prescaler
    row(0,0,8'h00,8'h00,1,0, 1,0,8'h00,8'h09);
    idle(3, 1, 8'h00, 8'h09);
    idle(1, 1, 8'h00, 8'h08);
    row(1,0,8'h00,8'h00,0,0, 0,0,8'h00,8'h00);
    row(0,1,8'h00,8'h03,1,0, 1,0,8'h00,8'h03);          // load+start uses new value
    idle(1, 1, 8'h00, 8'h03);
    row(1,0,8'h00,8'h00,0,0, 0,0,8'h00,8'h00);
    row(0,1,8'h00,8'h03,1,1, 0,0,8'h00,8'h03);          // pause wins in IDLE
    row(0,0,8'h00,8'h00,0,1, 0,0,8'h00,8'h03);          // pause in IDLE ignored
    row(0,1,8'h10,8'h00,0,0, 0,0,8'h10,8'h00);          // minute-tens borrow
    row(0,0,8'h00,8'h00,1,0, 1,0,8'h10,8'h00);
    idle(3, 1, 8'h10, 8'h00);
    idle(1, 1, 8'h09, 8'h59);
    row(1,0,8'h00,8'h00,0,0, 0,0,8'h00,8'h00);
    row(0,1,8'h03,8'h21,0,0, 0,0,8'h03,8'h21);          // reset mid-RUN
    row(0,0,8'h00,8'h00,1,0, 1,0,8'h03,8'h21);
    idle(2, 1, 8'h03, 8'h21);
    row(1,1,8'h09,8'h09,1,0, 0,0,8'h00,8'h00);
    idle(2, 0, 8'h00, 8'h00);

    // ---------------- apply table through the scoreboard ----------------
    for (int i = 0; i < vec_q.size(); i++) begin
      v = vec_q[i];
      rst = v.r; load = v.ld; load_min = v.lm; load_sec = v.ls;
      start = v.st; pause = v.pa;
      if (v.r) begin
        m_scan = 0;
        m_slot = 0;
        e.dg   = 4'h0;
      end else begin
        if (m_scan == 1) begin
          m_scan = 0;
          m_slot = (m_slot + 1) % 4;
        end else begin
          m_scan = m_scan + 1;
        end
        e.dg = exp_digit(m_slot, pm, ps);
      end
      e.idx = i; e.run = v.e_run; e.done = v.e_done; e.mn = v.e_min; e.sc = v.e_sec;
      e.an  = 4'b1111 & ~(4'b0001 << m_slot);
      sb_q.push_back(e);
      pm = v.e_min;
      ps = v.e_sec;
      cyc();
      g = sb_q.pop_front();
      checks++;
      if ({run, done, time_min, time_sec} !== {g.run, g.done, g.mn, g.sc}) begin
        failures++;
        $display("FAIL row%0d state: got run=%b done=%b time=%h:%h want run=%b done=%b time=%h:%h",
                 g.idx, run, done, time_min, time_sec, g.run, g.done, g.mn, g.sc);
      end
      checks++;
      if ({an, digit} !== {g.an, g.dg}) begin
        failures++;
        $display("FAIL row%0d display: got an=%b digit=%h want an=%b digit=%h",
                 g.idx, an, digit, g.an, g.dg);
      end
    end
    rst = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;

    // ---------------- hand sequence: bounded wait for done ----------------
    rst = 1'b1; cyc(); rst = 1'b0;
    load = 1'b1; load_min = 8'h00; load_sec = 8'h01; cyc(); load = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    n = 0; got = 1'b0;
    while (n < 20 && !got) begin
      cyc();
      n++;
      if (done === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got || n != 4) begin
      failures++;
      $display("FAIL done_latency: got seen=%0d cycles=%0d want seen=1 cycles=4", got, n);
    end
    checks++;
    if ({run, time_min, time_sec} !== {1'b0, 8'h00, 8'h00}) begin
      failures++;
      $display("FAIL done_state: got run=%b time=%h:%h want run=0 time=00:00", run, time_min, time_sec);
    end
    cyc();
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL done_width: got done=%b want 0", done);
    end

    // ---------------- hand sequence: leading-zero blanking ----------------
    load = 1'b1; load_min = 8'h10; load_sec = 8'h00; cyc(); load = 1'b0;
    cyc(); cyc();
    wait_an(4'b0111, ok);
    checks++;
    if (!ok || digit !== 4'h1) begin
      failures++;
      $display("FAIL blank_10_slot3: got found=%0d digit=%h want found=1 digit=1", ok, digit);
    end
    wait_an(4'b1011, ok);
    checks++;
    if (!ok || digit !== 4'h0) begin
      failures++;
      $display("FAIL blank_10_slot2: got found=%0d digit=%h want found=1 digit=0", ok, digit);
    end
    load = 1'b1; load_min = 8'h09; load_sec = 8'h00; cyc(); load = 1'b0;
    cyc(); cyc();
    wait_an(4'b0111, ok);
    checks++;
    if (!ok || digit !== 4'hF) begin
      failures++;
      $display("FAIL blank_09_slot3: got found=%0d digit=%h want found=1 digit=f", ok, digit);
    end
    wait_an(4'b1011, ok);
    checks++;
    if (!ok || digit !== 4'h9) begin
      failures++;
      $display("FAIL blank_09_slot2: got found=%0d digit=%h want found=1 digit=9", ok, digit);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wash_timer_scan.md
WASH_TIMER_SCAN -- requirements
Module: wash_timer_scan

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50_000_000, clk cycles per countdown second (>=2).
REQ-002 SHALL have parameter SCAN_DIV, default 50_000, clk cycles per display digit slot (>=2).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port load  input  1  one-cycle request to load load_min/load_sec.
REQ-006 SHALL have port load_min  input  8  BCD minutes {tens,ones}, 00-99.
REQ-007 SHALL have port load_sec  input  8  BCD seconds {tens,ones}, 00-59.
REQ-008 SHALL have port start  input  1  one-cycle request to begin or resume countdown.
REQ-009 SHALL have port pause  input  1  one-cycle request to suspend countdown.
REQ-010 SHALL have port run  output  1  high while in RUN.
REQ-011 SHALL have port done  output  1  one-cycle pulse when countdown reaches 00:00.
REQ-012 SHALL have port time_min  output  8  current BCD minutes.
REQ-013 SHALL have port time_sec  output  8  current BCD seconds.
REQ-014 SHALL have port digit  output  4  BCD code for the 7-seg decoder; 4'hF = blank.
REQ-015 SHALL have port an  output  4  active-low one-hot digit enable.

Function
REQ-016 SHALL implement states IDLE, RUN, PAUSED; run = (state==RUN).
REQ-017 load SHALL be accepted only in IDLE or PAUSED; in RUN it is ignored.
REQ-018 Accepted load SHALL be rejected (no change) if any BCD nibble >9 or sec tens >5.
REQ-019 Valid accepted load SHALL update time_min/time_sec next cycle, clear second prescaler, state unchanged.
REQ-020 start in IDLE/PAUSED with time != 00:00 SHALL enter RUN next cycle; with time == 00:00 SHALL be ignored, no done.
REQ-021 pause in RUN SHALL enter PAUSED next cycle; pause elsewhere ignored.
REQ-022 start and pause same cycle: pause wins (RUN->PAUSED; IDLE/PAUSED stay unchanged); load same cycle as start: load applied, start honoured using the new value.
REQ-023 Second prescaler SHALL count 0..TICK_DIV-1 only in RUN, hold in PAUSED (partial second preserved), clear in IDLE.
REQ-024 On prescaler value TICK_DIV-1 in RUN: prescaler->0, time decrements by one second next cycle.
REQ-025 Decrement SHALL be BCD with borrow: sec ones 0->9 borrowing tens; sec 00->59 borrowing minute; min ones 0->9 borrowing min tens.
REQ-026 When decrement yields 00:00: done=1 in the same cycle time shows 00:00, state->IDLE, run=0 that cycle; done exactly one cycle.
REQ-027 Scan counter SHALL run freely 0..SCAN_DIV-1 in all states; at SCAN_DIV-1 slot index 0->1->2->3->0.
REQ-028 Slot mapping: 0 an=1110 sec ones; 1 an=1101 sec tens; 2 an=1011 min ones; 3 an=0111 min tens.
REQ-029 digit and an SHALL be registered and change in the same cycle, never mismatched.
REQ-030 Leading-zero blanking: slot 3 with min tens==0 SHALL output digit=4'hF; no other blanking.
REQ-031 digit SHALL reflect time as of the cycle the slot is entered; a time change mid-slot updates digit on the next cycle.

Reset
REQ-032 rst SHALL take priority over all inputs, effective at next edge, in any state.
REQ-033 After reset: state IDLE, run=0, done=0, time 00:00, prescalers 0, slot 0, an=4'b1110, digit=4'h0.

Verification (TICK_DIV=4, SCAN_DIV=2)
REQ-034 load 01:00, start -> run=1; after 4 RUN cycles time 00:59; after 8 more 00:57; slot 3 shows 4'hF, slot 2 shows 0 while minutes 00.
REQ-035 load 00:02, start -> done high exactly one cycle 8 cycles after RUN entry, time 00:00, run=0 same cycle, state IDLE.
REQ-036 load 00:05, start, pause after 2 RUN cycles, hold 10 cycles, start -> time 00:05 during pause; 00:04 exactly 2 cycles after re-entering RUN.
REQ-037 load 00:7A and load 00:60 -> time unchanged; load 05:00 during RUN -> ignored; start with 00:00 in IDLE -> stays IDLE, no done.
REQ-038 start+pause same cycle in RUN -> PAUSED; rst asserted mid-RUN at 03:21 -> next cycle all REQ-033 values, done stays 0.
